mips_multi_core: RTL and testbench
==================================

// Module: mips_multi_core
// PURPOSE
// - Parametrised multicycle MIPS-subset core; successor to the fixed-width board core.
// - Fetches from a synchronous instruction ROM and executes one instruction at a time.
// - Talks to the data cache over a req/ack handshake that tolerates any number of wait cycles.
// - Adds a sign-extended immediate, bne/and/or/slt, a halt-on-illegal state and a debug register read port.
// PARAMETERS
// - PC_WIDTH     10  instruction word-address width; PC wraps modulo 2**PC_WIDTH
// - DADDR_WIDTH  12  data word-address width presented to the cache
// - DBG_SEL_W     5  debug register select width (fixed by the 32-entry file)
// PORTS
// - clk          in   1            core clock (the board clock divider tap is selected outside)
// - KEY0         in   1            synchronous active-low reset (pushbutton KEY[0])
// - imem_addr    out  PC_WIDTH     ROM word address; ROM data valid one clk later
// - imem_rdata   in   32           ROM data
// - dmem_req     out  1            data access request, held until ack
// - dmem_we      out  1            1 = store, 0 = load; valid while req
// - dmem_addr    out  DADDR_WIDTH  data word address; valid while req
// - dmem_wdata   out  32           store data (full R[rt] value); valid while req
// - dmem_ack     in   1            cache completes the access this cycle
// - dmem_rdata   in   32           load data, sampled only when req&&ack&&!we
// - dbg_sel      in   5            register to expose
// - dbg_data     out  32           R[dbg_sel], combinational
// - halted       out  1            core stopped on an illegal instruction
// BEHAVIOUR
// - Reset (KEY0=0 at posedge), including mid-handshake:
//   - state=IF, pc=0, IR=0, A=B=ALUOut=MDR=0, regfile cleared.
//   - dmem_req=0, dmem_we=0, halted=0.
// - States: IF->ID->EX->{WB | MEM->[WB] | IF}; HALT is absorbing until reset.
// - IF: imem_addr=pc.
// - ID:
//   - IR<=imem_rdata; pc<=pc+1.
//   - A<=R[rs], B<=R[rt], decoded from imem_rdata.
//   - j: pc<=imem_rdata[PC_WIDTH-1:0], next IF.
//   - Illegal opcode or funct: ->HALT, no state update.
// - EX, ALU on 32-bit two's complement, overflow ignored:
//   - add, sub, and, or, slt (signed): ALUOut<=result, next WB.
//   - addi: ALUOut<=A+sext(imm16), next WB.
//   - lw/sw: ALUOut<=A+sext(imm16), next MEM.
//   - beq/bne: if taken, pc<=pc+sext(imm16), truncated, wrap allowed; next IF.
// - MEM:
//   - dmem_req=1, dmem_addr=ALUOut[DADDR_WIDTH-1:0], dmem_we=(sw), dmem_wdata=B.
//   - All four signals are stable from the first MEM cycle until the ack cycle.
//   - Ack in the same cycle as the first req is legal: zero wait states.
//   - On ack: lw MDR<=dmem_rdata -> WB; sw -> IF.
//   - req deasserts in the cycle after ack.
//   - ack while not in MEM is ignored.
// - WB:
//   - Destination: rd for R-type, rt for addi/lw.
//   - Data: MDR for lw, otherwise ALUOut.
//   - Writes to r0 are discarded; r0 always reads 0.
// - HALT: halted=1, no req, pc frozen, dbg_data still live.
// - Latency in clk cycles, N = ack wait cycles:
//   - j = 2; beq/bne = 3; R-type/addi = 4.
//   - sw = 4+N; lw = 5+N.
// STRUCTURE
// - Package mips_multi_pkg holds:
//   - opcode/funct localparams: R=000000, addi=001000, beq=000100, bne=000101, j=000010, lw=100011, sw=101011.
//   - funct values: add=100000, sub=100010, and=100100, or=100101, slt=101010.
//   - state encoding, ALU-op codes.
// - Sub-module mips_regfile:
//   - 32x32, 2 async read ports + debug read port.
//   - 1 sync write port, synchronous clear on reset.
// - Core holds the FSM, datapath registers, ALU and handshake.
// TESTING
// - Reset then addi r1,r0,-5 -> R1=0xFFFFFFFB after 4 cycles; halted=0.
// - add/sub/slt with r1=7, r2=-3: add->4, sub->10, slt r3,r2,r1 ->1; write to r0 leaves R0=0.
// - sw r1,4(r0) with ack delayed 3 cycles -> req/we/addr=4/wdata=7 stable 4 cycles, next fetch at +1.
// - lw r5,4(r0) with zero-wait ack returning 0x12345678 -> R5=0x12345678, instruction takes 5 cycles.
// - beq taken at pc=1023 with imm=+2 -> pc wraps to 1; bne not taken -> pc+1; j 0x3FF -> imem_addr=1023.
// - Illegal opcode 111111 -> halted=1, no dmem_req; KEY0 low during a waiting MEM -> req=0 next cycle, pc=0.

Source files
------------

// File: rtl/mips_multi_pkg.sv
// Shared encodings for the multicycle MIPS-subset core: opcodes, functs, FSM states, ALU ops.
// Decode helpers live here so the core and any future units agree on what counts as legal.
package mips_multi_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_R:    ok = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                          (fn == FN_OR)  || (fn == FN_SLT);
            OP_ADDI, OP_BEQ, OP_BNE, OP_J, OP_LW, OP_SW: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic alu_op_t alu_decode(input logic [5:0] fn);
        alu_op_t op;
        case (fn)
            FN_SUB:  op = ALU_SUB;
            FN_AND:  op = ALU_AND;
            FN_OR:   op = ALU_OR;
            FN_SLT:  op = ALU_SLT;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mips_multi_if.sv
// Data-cache req/ack bundle; the core is master, the cache is slave.
interface mips_multi_if #(
    parameter int DADDR_WIDTH = 12
);
    logic                   dmem_req;
    logic                   dmem_we;
    logic [DADDR_WIDTH-1:0] dmem_addr;
    logic [31:0]            dmem_wdata;
    logic                   dmem_ack;
    logic [31:0]            dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mips_regfile.sv
// 32x32 register file: two async read ports, one async debug port, one sync write port.
// r0 is never written, so it stays at the cleared value of zero.
module mips_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    input  logic [4:0]  i_rad,
    input  logic        i_we,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2,
    output logic [31:0] o_rdd
);
    logic [31:0] r_regs [32];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (i_we && (i_wa != 5'd0)) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    assign o_rd1 = r_regs[i_ra1];
    assign o_rd2 = r_regs[i_ra2];
    assign o_rdd = r_regs[i_rad];
endmodule

// File: rtl/mips_multi_core.sv
// Multicycle MIPS-subset core: IF/ID/EX/MEM/WB sequencer with a req/ack data port.
// Fetch assumes a ROM with one cycle of read latency, so ID consumes imem_rdata directly.
module mips_multi_core
    import mips_multi_pkg::*;
#(
    parameter int PC_WIDTH    = 10,
    parameter int DADDR_WIDTH = 12,
    parameter int DBG_SEL_W   = 5
) (
    input  logic                 clk,
    input  logic                 KEY0,
    output logic [PC_WIDTH-1:0]  imem_addr,
    input  logic [31:0]          imem_rdata,
    mips_multi_if.master         dmem,
    input  logic [DBG_SEL_W-1:0] dbg_sel,
    output logic [31:0]          dbg_data,
    output logic                 halted
);
    state_t              r_state, w_state_next;
    logic [PC_WIDTH-1:0] r_pc;
    logic [31:0]         r_ir, r_a, r_b, r_aluout, r_mdr;

    logic [5:0]  w_op, w_id_op;
    logic [31:0] w_imm, w_alu_b, w_alu_y, w_rd1, w_rd2, w_rf_wd;
    logic [4:0]  w_ra1, w_ra2, w_rf_wa;
    logic        w_rf_we, w_id_legal, w_br_taken;
    alu_op_t     w_alu_op;

    assign w_op       = r_ir[31:26];
    assign w_id_op    = imem_rdata[31:26];
    assign w_id_legal = is_legal(w_id_op, imem_rdata[5:0]);
    assign w_imm      = sext16(r_ir[15:0]);

    // Read ports follow the instruction arriving from the ROM while decoding, IR otherwise.
    assign w_ra1 = (r_state == S_ID) ? imem_rdata[25:21] : r_ir[25:21];
    assign w_ra2 = (r_state == S_ID) ? imem_rdata[20:16] : r_ir[20:16];

    assign w_rf_we = (r_state == S_WB);
    assign w_rf_wa = (w_op == OP_R) ? r_ir[15:11] : r_ir[20:16];
    assign w_rf_wd = (w_op == OP_LW) ? r_mdr : r_aluout;

    mips_regfile u_regfile (
        .clk   (clk),
        .rst_n (KEY0),
        .i_ra1 (w_ra1),
        .i_ra2 (w_ra2),
        .i_rad (dbg_sel),
        .i_we  (w_rf_we),
        .i_wa  (w_rf_wa),
        .i_wd  (w_rf_wd),
        .o_rd1 (w_rd1),
        .o_rd2 (w_rd2),
        .o_rdd (dbg_data)
    );

    assign w_alu_op = (w_op == OP_R) ? alu_decode(r_ir[5:0]) : ALU_ADD;
    assign w_alu_b  = (w_op == OP_R) ? r_b : w_imm;

    always_comb begin
        case (w_alu_op)
            ALU_SUB: w_alu_y = r_a - w_alu_b;
            ALU_AND: w_alu_y = r_a & w_alu_b;
            ALU_OR:  w_alu_y = r_a | w_alu_b;
            ALU_SLT: w_alu_y = {31'd0, ($signed(r_a) < $signed(w_alu_b))};
            default: w_alu_y = r_a + w_alu_b;
        endcase
    end

    assign w_br_taken = ((w_op == OP_BEQ) && (r_a == r_b)) ||
                        ((w_op == OP_BNE) && (r_a != r_b));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IF:  w_state_next = S_ID;
            S_ID: begin
                if (!w_id_legal)          w_state_next = S_HALT;
                else if (w_id_op == OP_J) w_state_next = S_IF;
                else                      w_state_next = S_EX;
            end
            S_EX: begin
                case (w_op)
                    OP_R, OP_ADDI: w_state_next = S_WB;
                    OP_LW, OP_SW:  w_state_next = S_MEM;
                    default:       w_state_next = S_IF;
                endcase
            end
            S_MEM: if (dmem.dmem_ack) w_state_next = (w_op == OP_LW) ? S_WB : S_IF;
            S_WB:   w_state_next = S_IF;
            S_HALT: w_state_next = S_HALT;
            default: w_state_next = S_IF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!KEY0) r_state <= S_IF;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (!KEY0) begin
            r_pc     <= '0;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
            r_mdr    <= '0;
        end else begin
            case (r_state)
                S_ID: if (w_id_legal) begin
                    r_ir <= imem_rdata;
                    r_a  <= w_rd1;
                    r_b  <= w_rd2;
                    r_pc <= (w_id_op == OP_J) ? imem_rdata[PC_WIDTH-1:0] : r_pc + PC_WIDTH'(1);
                end
                S_EX: begin
                    r_aluout <= w_alu_y;
                    if (w_br_taken) r_pc <= r_pc + w_imm[PC_WIDTH-1:0];
                end
                S_MEM: if (dmem.dmem_ack && (w_op == OP_LW)) r_mdr <= dmem.dmem_rdata;
                default: ;
            endcase
        end
    end

    assign imem_addr       = r_pc;
    assign halted          = (r_state == S_HALT);
    assign dmem.dmem_req   = (r_state == S_MEM);
    assign dmem.dmem_we    = (r_state == S_MEM) && (w_op == OP_SW);
    assign dmem.dmem_addr  = r_aluout[DADDR_WIDTH-1:0];
    assign dmem.dmem_wdata = r_b;
endmodule

// File: tb/tb_mips_multi_core.sv
// Directed bench: stimulus queues expected memory transactions and probes; monitor compares.
module tb_mips_multi_core;
    localparam int PK_REQ  = 0;
    localparam int PK_ADDR = 1;
    localparam int PK_HALT = 2;
    localparam int PK_REG  = 3;
    localparam logic [31:0] HALT_INSN = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        KEY0;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [4:0]  dbg_sel;
    logic [31:0] dbg_data;
    logic        halted;

    always #5 clk = ~clk;

    mips_multi_if #(.DADDR_WIDTH(12)) dif ();

    mips_multi_core #(.PC_WIDTH(10), .DADDR_WIDTH(12), .DBG_SEL_W(5)) dut (
        .clk        (clk),
        .KEY0       (KEY0),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .dmem       (dif),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data),
        .halted     (halted)
    );

    // Synchronous ROM and a cache model acking after ack_wait wait cycles.
    logic [31:0] rom [1024];
    int          ack_wait;
    logic [31:0] load_data;
    logic [7:0]  wcnt = 8'd0;

    always @(posedge clk) imem_rdata <= rom[imem_addr];
    always @(posedge clk) wcnt <= (!dif.dmem_req || dif.dmem_ack) ? 8'd0 : wcnt + 8'd1;
    assign dif.dmem_ack   = dif.dmem_req && (int'(wcnt) == ack_wait);
    assign dif.dmem_rdata = load_data;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        int          cycles;
        logic        acked;
    } mem_exp_t;

    typedef struct {
        int          kind;
        logic [4:0]  sel;
        logic [31:0] exp;
        string       name;
    } probe_t;

    mem_exp_t mem_q[$];
    probe_t   probe_q[$];
    logic     probe_v;
    int       n_pass = 0;
    int       n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            probe_v = 1'b0;
        end
    endtask

    task automatic probe(input int kind, input logic [4:0] sel, input logic [31:0] exp,
                         input string name);
        probe_t p;
        p.kind = kind;
        p.sel  = sel;
        p.exp  = exp;
        p.name = name;
        probe_q.push_back(p);
        dbg_sel = sel;
        probe_v = 1'b1;
    endtask

    task automatic expect_mem(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                              input int cycles, input logic acked);
        mem_exp_t e;
        e.we = we;
        e.addr = addr;
        e.wdata = wdata;
        e.cycles = cycles;
        e.acked = acked;
        mem_q.push_back(e);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) rom[i] = HALT_INSN;
    endtask

    // Reset for four cycles, probing outputs and one register that held data beforehand.
    task automatic hold_reset(input logic [4:0] reg_idx);
        KEY0 = 1'b0;
        step(1);
        probe(PK_REQ, 5'd0, 32'd0, "rst_req");
        step(1);
        probe(PK_ADDR, 5'd0, 32'd0, "rst_pc");
        step(1);
        probe(PK_HALT, 5'd0, 32'd0, "rst_halted");
        step(1);
        probe(PK_REG, reg_idx, 32'd0, "rst_reg");
        KEY0 = 1'b1;
    endtask

    logic        m_active = 1'b0;
    logic        m_we, m_stable;
    logic [11:0] m_addr;
    logic [31:0] m_wdata;
    int          m_cnt;

    task automatic mem_done(input logic acked);
        mem_exp_t e;
        m_active = 1'b0;
        $display("mem txn we=%0b addr=%0h wdata=%08h cycles=%0d acked=%0b",
                 m_we, m_addr, m_wdata, m_cnt, acked);
        if (mem_q.size() != 0) begin
            e = mem_q.pop_front();
            check("mem_fields", {m_we, m_addr, m_wdata}, {e.we, e.addr, e.wdata});
            check("mem_req_cycles", m_cnt, e.cycles);
            check("mem_acked", acked, e.acked);
            check("mem_stable", m_stable, 1'b1);
        end
    endtask

    always @(negedge clk) begin
        probe_t      p;
        logic [31:0] act;
        if (probe_v && (probe_q.size() != 0)) begin
            p = probe_q.pop_front();
            case (p.kind)
                PK_REQ:  act = {31'd0, dif.dmem_req};
                PK_ADDR: act = {22'd0, imem_addr};
                PK_HALT: act = {31'd0, halted};
                default: act = dbg_data;
            endcase
            $display("probe %s sel=%0d act=%08h exp=%08h", p.name, p.sel, act, p.exp);
            check(p.name, act, p.exp);
        end
        if (dif.dmem_req === 1'b1) begin
            if (!m_active) begin
                m_active = 1'b1;
                m_cnt    = 1;
                m_stable = 1'b1;
                m_we     = dif.dmem_we;
                m_addr   = dif.dmem_addr;
                m_wdata  = dif.dmem_wdata;
                check("mem_req_expected", (mem_q.size() != 0), 1'b1);
            end else begin
                m_cnt++;
                if ({dif.dmem_we, dif.dmem_addr, dif.dmem_wdata} !== {m_we, m_addr, m_wdata})
                    m_stable = 1'b0;
            end
            if (dif.dmem_ack) mem_done(1'b1);
        end else if (m_active) begin
            mem_done(1'b0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the bench finished");
        $fatal(1, "watchdog");
    end

    initial begin
        KEY0      = 1'b0;
        dbg_sel   = 5'd0;
        probe_v   = 1'b0;
        ack_wait  = 0;
        load_data = 32'd0;
        clear_rom();

        // addi r1,r0,-5 then halt
        rom[0] = 32'h2001_FFFB;
        hold_reset(5'd1);
        step(3); probe(PK_REG, 5'd1, 32'd0,         "addi_not_yet");
        step(1); probe(PK_REG, 5'd1, 32'hFFFF_FFFB, "addi_r1");
        step(1); probe(PK_HALT, 5'd0, 32'd0,        "addi_no_halt");
        step(1); probe(PK_HALT, 5'd0, 32'd1,        "halt_after_addi");

        // r1=7, r2=-3 then add/sub/slt/r0/and/or/slt
        clear_rom();
        rom[0] = 32'h2001_0007;
        rom[1] = 32'h2002_FFFD;
        rom[2] = 32'h0022_1820;  // add r3,r1,r2
        rom[3] = 32'h0022_2022;  // sub r4,r1,r2
        rom[4] = 32'h0041_282A;  // slt r5,r2,r1
        rom[5] = 32'h0022_0020;  // add r0,r1,r2
        rom[6] = 32'h0022_3024;  // and r6,r1,r2
        rom[7] = 32'h0022_3825;  // or  r7,r1,r2
        rom[8] = 32'h0022_402A;  // slt r8,r1,r2
        hold_reset(5'd1);
        step(40); probe(PK_REG, 5'd3, 32'd4,         "add_r3");
        step(1);  probe(PK_REG, 5'd4, 32'd10,        "sub_r4");
        step(1);  probe(PK_REG, 5'd5, 32'd1,         "slt_true");
        step(1);  probe(PK_REG, 5'd0, 32'd0,         "r0_zero");
        step(1);  probe(PK_REG, 5'd6, 32'd5,         "and_r6");
        step(1);  probe(PK_REG, 5'd7, 32'hFFFF_FFFF, "or_r7");
        step(1);  probe(PK_REG, 5'd8, 32'd0,         "slt_false");
        step(1);  probe(PK_REG, 5'd2, 32'hFFFF_FFFD, "addi_neg_r2");

        // sw r1,4(r0) with three wait cycles
        clear_rom();
        rom[0] = 32'h2001_0007;
        rom[1] = 32'hAC01_0004;
        ack_wait = 3;
        expect_mem(1'b1, 12'd4, 32'd7, 4, 1'b1);
        hold_reset(5'd3);
        step(10); probe(PK_REQ, 5'd0, 32'd1,  "sw_req_ack_cycle");
        step(1);  probe(PK_REQ, 5'd0, 32'd0,  "sw_req_drop");
        step(1);  probe(PK_HALT, 5'd0, 32'd0, "sw_next_decode");
        step(1);  probe(PK_HALT, 5'd0, 32'd1, "sw_fetch_plus1");

        // lw r5,4(r0) with zero wait states
        clear_rom();
        rom[0] = 32'h8C05_0004;
        ack_wait = 0;
        load_data = 32'h1234_5678;
        expect_mem(1'b0, 12'd4, 32'd0, 1, 1'b1);
        hold_reset(5'd1);
        step(4); probe(PK_REG, 5'd5, 32'd0,         "lw_not_yet");
        step(1); probe(PK_REG, 5'd5, 32'h1234_5678, "lw_r5");
        step(2); probe(PK_HALT, 5'd0, 32'd1,        "lw_then_halt");

        // beq is fetched from 1022, so pc holds 1023 when it executes and wraps to 1
        clear_rom();
        rom[0]    = 32'h0800_03FE;  // j 1022
        rom[1022] = 32'h1000_0002;  // beq r0,r0,+2
        rom[1]    = 32'h1400_0005;  // bne r0,r0,+5
        rom[2]    = 32'h0800_03FF;  // j 0x3FF
        hold_reset(5'd5);
        step(2); probe(PK_ADDR, 5'd0, 32'd1022, "j_target");
        step(3); probe(PK_ADDR, 5'd0, 32'd1,    "beq_wrap");
        step(3); probe(PK_ADDR, 5'd0, 32'd2,    "bne_not_taken");
        step(2); probe(PK_ADDR, 5'd0, 32'd1023, "j_3ff");
        step(2); probe(PK_HALT, 5'd0, 32'd1,    "halt_at_1023");

        // illegal funct after addi: halt, pc frozen, debug port live
        clear_rom();
        rom[0] = 32'h2001_0007;
        rom[1] = 32'h0022_180F;
        hold_reset(5'd2);
        step(5); probe(PK_HALT, 5'd0, 32'd0, "illegal_decode");
        step(1); probe(PK_HALT, 5'd0, 32'd1, "illegal_halt");
        step(1); probe(PK_ADDR, 5'd0, 32'd1, "halt_pc_frozen");
        step(1); probe(PK_REG, 5'd1, 32'd7,  "dbg_live");
        step(1); probe(PK_REG, 5'd3, 32'd0,  "illegal_no_wb");
        step(3); probe(PK_REQ, 5'd0, 32'd0,  "halt_no_req");

        // reset while a store waits for an ack that never comes
        clear_rom();
        rom[0] = 32'h2001_0007;
        rom[1] = 32'hAC01_0008;
        ack_wait = 255;
        expect_mem(1'b1, 12'd8, 32'd7, 3, 1'b0);
        hold_reset(5'd1);
        step(9);
        hold_reset(5'd1);
        clear_rom();
        step(2); probe(PK_HALT, 5'd0, 32'd1, "restart_halts");

        step(2);
        check("queues_drained", mem_q.size() + probe_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
